// File: rtl/reg_master.sv
// reg_master: turns one command at a time into a single-strobe register-bus
// access. It waits for ack with a bounded timeout and holds the response
// until the consumer accepts it.
module reg_master #(
    parameter int unsigned ADDR_SIZE_P = 4,
    parameter int unsigned TIMEOUT_P   = 15
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rd_wr,
    input  logic [ADDR_SIZE_P-1:0] cmd_addr,
    input  logic [31:0]            cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_SIZE_P-1:0] addr,
    output logic                   rd_wr,
    output logic                   req,
    output logic [31:0]            write_val,
    input  logic [31:0]            read_val,
    input  logic                   ack,
    output logic [7:0]             timeout_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_P);

    state_t                 state_q, state_d;
    logic [ADDR_SIZE_P-1:0] addr_q, addr_d;
    logic                   rd_wr_q, rd_wr_d;
    logic [31:0]            wval_q, wval_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [7:0]             tcnt_q, tcnt_d;

    // State and datapath registers, cleared asynchronously so reset aborts any transaction
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_wr_q    <= 1'b0;
            wval_q     <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_wr_q    <= rd_wr_d;
            wval_q     <= wval_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Next-state logic: accept, strobe, wait for ack or timeout, hold response
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_wr_d    = rd_wr_q;
        wval_d     = wval_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tcnt_d     = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = REQ;
                    addr_d  = cmd_addr;
                    rd_wr_d = cmd_rd_wr;
                    // Reads keep the previous write data on the bus
                    if (!cmd_rd_wr) wval_d = cmd_wdata;
                end
            end
            REQ: begin
                state_d    = WAIT;
                wait_cnt_d = 8'd1;
            end
            WAIT: begin
                // ack takes priority over a timeout in the same cycle
                if (ack) begin
                    rdata_d    = rd_wr_q ? read_val : '0;
                    err_d      = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = RESP;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE) && reset_L;
    assign req         = (state_q == REQ);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign addr        = addr_q;
    assign rd_wr       = rd_wr_q;
    assign write_val   = wval_q;
    assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_reg_master.sv
// Directed bench for reg_master: table of single transactions plus
// hand-written sequences for backpressure, stray ack, reset abort and
// timeout counter saturation.
module tb_reg_master;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd_wr;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  addr;
    logic        rd_wr;
    logic        req;
    logic [31:0] write_val;
    logic [31:0] read_val;
    logic        ack;
    logic [7:0]  timeout_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    reg_master #(.ADDR_SIZE_P(4), .TIMEOUT_P(15)) dut (
        .clk(clk), .reset_L(reset_L),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .addr(addr), .rd_wr(rd_wr), .req(req),
        .write_val(write_val), .read_val(read_val), .ack(ack),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ack_at: WAIT cycle (1-based) carrying ack, 0 = never ack.
    // exp_lat: clock edges from the accept edge until rsp_valid is seen.
    typedef struct {
        logic        rd;
        logic [3:0]  a;
        logic [31:0] wdata;
        int          ack_at;
        logic [31:0] rval;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_tcnt;
        logic [31:0] exp_wval;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bad;
        bad = 0;
        cmd_valid = 1'b1; cmd_rd_wr = v.rd; cmd_addr = v.a; cmd_wdata = v.wdata;
        #1 check($sformatf("v%0d cmd_ready", idx), 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_wdata = 32'h0BAD_0BAD; cmd_addr = ~v.a;
        check($sformatf("v%0d req", idx), 32'(req), 32'd1);
        check($sformatf("v%0d addr", idx), 32'(addr), 32'(v.a));
        check($sformatf("v%0d rd_wr", idx), 32'(rd_wr), 32'(v.rd));
        check($sformatf("v%0d write_val", idx), write_val, v.exp_wval);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) begin
                if (req || cmd_ready || addr != v.a || rd_wr != v.rd || write_val != v.exp_wval) bad++;
                ack      = (lat - 1 == v.ack_at);
                read_val = ack ? v.rval : 32'hDEAD_BEEF;
            end else begin
                ack = 1'b0;
            end
        end
        ack = 1'b0;
        check($sformatf("v%0d wait bus stable", idx), 32'(bad), 32'd0);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d timeout_cnt", idx), 32'(timeout_cnt), 32'(v.exp_tcnt));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d rsp_valid drop", idx), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int bad;
        int nresp;
        logic [7:0] t_before;

        reset_L = 1'b0; cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; read_val = '0; ack = 1'b0;

        //            rd    a     wdata          ack  rval           rdata          err   tcnt  wval           lat
        vecs[0] = '{1'b0, 4'h1, 32'h0000_00A5,  1, 32'h1111_1111, 32'h0,         1'b0, 8'd0, 32'h0000_00A5,  3};
        vecs[1] = '{1'b1, 4'h0, 32'h0,          3, 32'h1234_5678, 32'h1234_5678, 1'b0, 8'd0, 32'h0000_00A5,  5};
        vecs[2] = '{1'b1, 4'h3, 32'h0,          0, 32'h0,         32'h0,         1'b1, 8'd1, 32'h0000_00A5, 17};
        vecs[3] = '{1'b1, 4'h5, 32'h0,         15, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 8'd1, 32'h0000_00A5, 17};
        vecs[4] = '{1'b0, 4'hF, 32'h5A5A_5A5A, 14, 32'h2222_2222, 32'h0,         1'b0, 8'd1, 32'h5A5A_5A5A, 16};
        vecs[5] = '{1'b0, 4'h2, 32'h0000_0001,  0, 32'h0,         32'h0,         1'b1, 8'd2, 32'h0000_0001, 17};
        vecs[6] = '{1'b1, 4'h7, 32'h0,          2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'd2, 32'h0000_0001,  4};

        // Reset state
        #2;
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset req", 32'(req), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset addr", 32'(addr), 32'd0);
        check("reset write_val", write_val, 32'd0);
        check("reset timeout_cnt", 32'(timeout_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        #1 check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: response held 10 cycles with stray ack and cmd_valid high
        cmd_valid = 1'b1; cmd_rd_wr = 1'b1; cmd_addr = 4'h4;
        @(negedge clk);
        @(negedge clk); ack = 1'b1; read_val = 32'h0BAD_F00D;
        @(negedge clk); ack = 1'b0;
        check("hold rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ack = i[0]; read_val = $urandom;
            @(negedge clk);
            if (!rsp_valid || rsp_rdata != 32'h0BAD_F00D || rsp_err || cmd_ready || req) bad++;
        end
        ack = 1'b0;
        check("hold stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1; cmd_addr = 4'h6;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold release cmd_ready", 32'(cmd_ready), 32'd1);
        check("hold release req", 32'(req), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("second req", 32'(req), 32'd1);
        check("second addr", 32'(addr), 32'h6);
        @(negedge clk); ack = 1'b1; read_val = 32'h6666_0006;
        @(negedge clk); ack = 1'b0; rsp_ready = 1'b1;
        check("second rdata", rsp_rdata, 32'h6666_0006);
        @(negedge clk); rsp_ready = 1'b0;

        // Stray ack in IDLE has no effect
        t_before = timeout_cnt;
        ack = 1'b1;
        repeat (2) @(negedge clk);
        ack = 1'b0;
        check("stray ack rsp_valid", 32'(rsp_valid), 32'd0);
        check("stray ack req", 32'(req), 32'd0);
        check("stray ack tcnt", 32'(timeout_cnt), 32'(t_before));

        // Reset during WAIT, then a late ack
        cmd_valid = 1'b1; cmd_rd_wr = 1'b0; cmd_addr = 4'h9; cmd_wdata = 32'h77;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        check("abort addr", 32'(addr), 32'd0);
        check("abort write_val", write_val, 32'd0);
        check("abort timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset_L = 1'b1; ack = 1'b1;
        #1 check("abort post cmd_ready", 32'(cmd_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ack = 1'b0;
            if (rsp_valid || req || !cmd_ready) bad++;
        end
        check("abort no response", 32'(bad), 32'd0);

        // Timeout counter saturates at 255
        cmd_valid = 1'b1; cmd_rd_wr = 1'b1; rsp_ready = 1'b1; ack = 1'b0;
        nresp = 0;
        for (int cyc = 0; cyc < 6000 && nresp < 260; cyc++) begin
            @(negedge clk);
            if (rsp_valid && rsp_err) nresp++;
        end
        cmd_valid = 1'b0;
        check("sat responses", 32'(nresp), 32'd260);
        check("sat timeout_cnt", 32'(timeout_cnt), 32'd255);
        @(negedge clk); rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_master.md
REG_MASTER -- requirements
Module: reg_master

Interface
REQ-001 Parameter ADDR_SIZE_P, default 4, sets the register address width.
REQ-002 Parameter TIMEOUT_P, default 15, is the number of WAIT cycles without ack before timeout; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset_L  input  1  asynchronous active-low reset.
REQ-005 Port cmd_valid  input  1  command present.
REQ-006 Port cmd_ready  output  1  block accepts a command this cycle.
REQ-007 Port cmd_rd_wr  input  1  command type: 1=read, 0=write.
REQ-008 Port cmd_addr  input  ADDR_SIZE_P  target register address.
REQ-009 Port cmd_wdata  input  32  write data; ignored for reads.
REQ-010 Port rsp_valid  output  1  response present.
REQ-011 Port rsp_ready  input  1  response consumer accepts.
REQ-012 Port rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-013 Port rsp_err  output  1  transaction timed out.
REQ-014 Port addr  output  ADDR_SIZE_P  register bus address.
REQ-015 Port rd_wr  output  1  register bus type: 1=read, 0=write.
REQ-016 Port req  output  1  register bus request strobe.
REQ-017 Port write_val  output  32  register bus write data.
REQ-018 Port read_val  input  32  register bus read data; valid only in the ack cycle.
REQ-019 Port ack  input  1  register bus completion strobe.
REQ-020 Port timeout_cnt  output  8  saturating count of timed-out transactions.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT and RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-023 On acceptance, cmd_rd_wr, cmd_addr and cmd_wdata SHALL be registered and the FSM SHALL go to REQ.
REQ-024 In REQ, req SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT.
REQ-025 addr, rd_wr and write_val SHALL drive the registered values from REQ through the last WAIT cycle, and hold those values otherwise; they SHALL never change mid-transaction.
REQ-026 For reads, write_val SHALL hold the last write data; it SHALL not be zeroed.
REQ-027 ack SHALL be ignored in IDLE, REQ and RESP; ack in IDLE/RESP counts as stray and has no effect.
REQ-028 In WAIT, an 8-bit wait counter SHALL start at 1 on entry and increment each cycle without ack.
REQ-029 ack=1 in WAIT SHALL capture rsp_rdata = read_val for a read, or 0 for a write, set rsp_err=0 and go to RESP.
REQ-030 If the wait counter equals TIMEOUT_P with ack=0, the FSM SHALL set rsp_err=1 and rsp_rdata=0, increment timeout_cnt (saturating at 255) and go to RESP.
REQ-031 If ack arrives in the same cycle the counter reaches TIMEOUT_P, ack SHALL win: no error and no timeout_cnt increment.
REQ-032 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be stable until rsp_valid && rsp_ready, then the FSM SHALL go to IDLE.
REQ-033 rsp_ready SHALL be ignored outside RESP.
REQ-034 Minimum command-to-command spacing SHALL be 4 cycles: accept, REQ, WAIT with ack, RESP with rsp_ready.
REQ-035 Response latency from acceptance SHALL be 2 + (WAIT cycles) cycles until rsp_valid rises.

Reset
REQ-036 While reset_L=0, asynchronously: FSM=IDLE; req=0, rsp_valid=0, rsp_err=0; rsp_rdata=0, addr=0, rd_wr=0, write_val=0; timeout_cnt=0; wait counter=0.
REQ-037 cmd_ready SHALL be 0 while reset_L=0 and SHALL be 1 in the first cycle after deassertion.
REQ-038 Reset mid-transaction SHALL abort it with no response; a late ack after reset SHALL be ignored.

Verification
REQ-039 Write addr 1, data 0x0000_00A5, ack 1 cycle after req -> req single pulse with addr=1, rd_wr=0, write_val=0xA5; rsp_valid 3 cycles after accept; rsp_err=0; rsp_rdata=0.
REQ-040 Read addr 0, ack 3 cycles after req with read_val=0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_err=0; addr held at 0 through all WAIT cycles.
REQ-041 Read with no ack, TIMEOUT_P=15 -> rsp_err=1 after 15 WAIT cycles; rsp_rdata=0; timeout_cnt 0->1.
REQ-042 ack coincident with the 15th WAIT cycle -> rsp_err=0, timeout_cnt unchanged.
REQ-043 rsp_ready held 0 for 10 cycles, stray ack pulses and cmd_valid=1 throughout -> response stable, cmd_ready=0, no second req until the response is accepted.
REQ-044 reset_L pulsed low during WAIT, then ack -> all outputs at reset values, no rsp_valid, cmd_ready=1 on the first post-reset cycle.
